// File: rtl/mc_defs.sv
// Shared definitions for the multicycle MIPS main control:
// opcodes, state codes, ALUOp codes and datapath mux selects.
`default_nettype none

package mc_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  // Shared with alucontrol
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_control.sv
// Multicycle MIPS main-control FSM: sequences datapath enables per step,
// stalling FETCH/MEMRD/MEMWR on mem_ready.
`default_nettype none

module mc_control
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore decode; reset masks everything so no write leaks during reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMMSH;
          case (Op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        S_MEMADR, S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_RTYPEWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        S_ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control with hand-computed control words.
`default_nettype none

module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst,PCSource[1:0],ALUOp[1:0],ALUSrcB[1:0],illegal_op}
  logic [16:0] w_ctrl;
  assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                   IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
                   ALUSrcB, illegal_op};

  localparam logic [16:0] C_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FETCH   = 17'b1_0_0_1_0_0_1_0_0_0_00_00_01_0;
  localparam logic [16:0] C_FETCHW  = 17'b0_0_0_1_0_0_0_0_0_0_00_00_01_0;
  localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_11_0;
  localparam logic [16:0] C_DECILL  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_11_1;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_RTYPEWB = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [16:0] C_BEQ     = 17'b0_1_0_0_0_0_0_1_0_0_01_01_00_0;
  localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_step(input string tag, input logic [3:0] s, input logic [16:0] c);
    check({tag, ".state"}, {28'd0, state}, {28'd0, s});
    check({tag, ".ctrl"},  {15'd0, w_ctrl}, {15'd0, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; Op = 6'b0; mem_ready = 1'b1;
    tick(); tick();
    expect_step("rst", 4'd0, C_ZERO);
    reset = 1'b0; #1;
    expect_step("rel_fetch", 4'd0, C_FETCH);

    // lw, zero wait: 0,1,2,3,4,0
    Op = 6'b100011;
    tick(); expect_step("lw_dec",   4'd1, C_DECODE);
    tick(); expect_step("lw_adr",   4'd2, C_MEMADR);
    tick(); expect_step("lw_rd",    4'd3, C_MEMRD);
    tick(); expect_step("lw_wb",    4'd4, C_MEMWB);
    tick(); expect_step("lw_fetch", 4'd0, C_FETCH);

    // R-type
    Op = 6'b000000;
    tick(); expect_step("r_dec",   4'd1, C_DECODE);
    tick(); expect_step("r_exec",  4'd6, C_EXEC);
    tick(); expect_step("r_wb",    4'd7, C_RTYPEWB);
    tick(); expect_step("r_fetch", 4'd0, C_FETCH);

    // sw with 3 wait cycles in MEMWR
    Op = 6'b101011;
    tick(); expect_step("sw_dec", 4'd1, C_DECODE);
    tick(); expect_step("sw_adr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_step("sw_wr_wait", 4'd5, C_MEMWR);
    end
    mem_ready = 1'b1; #1;
    expect_step("sw_wr_done", 4'd5, C_MEMWR);
    tick(); expect_step("sw_fetch", 4'd0, C_FETCH);

    // FETCH stall
    mem_ready = 1'b0; #1;
    expect_step("fetch_wait", 4'd0, C_FETCHW);
    tick(); expect_step("fetch_hold", 4'd0, C_FETCHW);
    mem_ready = 1'b1;

    // beq
    Op = 6'b000100;
    tick(); expect_step("beq_dec",   4'd1, C_DECODE);
    tick(); expect_step("beq_exe",   4'd8, C_BEQ);
    tick(); expect_step("beq_fetch", 4'd0, C_FETCH);

    // j
    Op = 6'b000010;
    tick(); expect_step("j_dec",   4'd1, C_DECODE);
    tick(); expect_step("j_exe",   4'd9, C_JUMP);
    tick(); expect_step("j_fetch", 4'd0, C_FETCH);

    // addi
    Op = 6'b001000;
    tick(); expect_step("addi_dec",   4'd1, C_DECODE);
    tick(); expect_step("addi_ex",    4'd10, C_MEMADR);
    tick(); expect_step("addi_wb",    4'd11, C_ADDIWB);
    tick(); expect_step("addi_fetch", 4'd0, C_FETCH);

    // illegal opcode
    Op = 6'b111111;
    tick(); expect_step("ill_dec",   4'd1, C_DECILL);
    tick(); expect_step("ill_fetch", 4'd0, C_FETCH);

    // lw stalled in MEMRD, Op changes ignored, then reset mid-instruction
    Op = 6'b100011;
    tick(); expect_step("rs_dec", 4'd1, C_DECODE);
    tick(); expect_step("rs_adr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    tick(); expect_step("rs_rd", 4'd3, C_MEMRD);
    Op = 6'b101011;
    tick(); expect_step("rs_rd_hold", 4'd3, C_MEMRD);
    reset = 1'b1; #1;
    expect_step("rs_rd_reset", 4'd3, C_ZERO);
    tick(); expect_step("rs_after", 4'd0, C_ZERO);
    reset = 1'b0; #1;
    expect_step("rs_fetch", 4'd0, C_FETCHW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
